axi_burst_beat_gen: RTL and testbench

// Expands one AXI4 AR/AW address-channel request into its per-beat address stream for
// the FIXED, INCR and WRAP burst types (axi_pkg::axi_burst_t). Sits between an AXI

---
 rtl/axi_burst_beat_gen_if.sv | 31 +++
 rtl/axi_burst_beat_gen.sv | 122 ++++++++++++
 tb/tb_axi_burst_beat_gen.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_beat_gen_if.sv
// Address-channel request in, per-beat address stream out, for axi_burst_beat_gen.
interface axi_burst_beat_gen_if #(
  parameter int AddrWidth = 56,
  parameter int IdWidth   = 4
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [IdWidth-1:0]   req_id_i;
  logic [AddrWidth-1:0] req_addr_i;
  logic [7:0]           req_len_i;
  logic [2:0]           req_size_i;
  logic [1:0]           req_burst_i;

  logic                 beat_valid_o;
  logic                 beat_ready_i;
  logic [IdWidth-1:0]   beat_id_o;
  logic [AddrWidth-1:0] beat_addr_o;
  logic [7:0]           beat_idx_o;
  logic                 beat_last_o;
  logic                 beat_err_o;

  modport slave (
    input  req_valid_i, req_id_i, req_addr_i, req_len_i, req_size_i, req_burst_i, beat_ready_i,
    output req_ready_o, beat_valid_o, beat_id_o, beat_addr_o, beat_idx_o, beat_last_o, beat_err_o
  );

  modport master (
    output req_valid_i, req_id_i, req_addr_i, req_len_i, req_size_i, req_burst_i, beat_ready_i,
    input  req_ready_o, beat_valid_o, beat_id_o, beat_addr_o, beat_idx_o, beat_last_o, beat_err_o
  );
endinterface

// File: rtl/axi_burst_beat_gen.sv
// Expands one AXI4 AR/AW request into per-beat addresses (FIXED/INCR/WRAP) and
// flags illegal bursts so the data path can answer them with SLVERR.
module axi_burst_beat_gen #(
  parameter int AddrWidth = 56,
  parameter int IdWidth   = 4,
  parameter int DataWidth = 64
) (
  input logic                clk_i,
  input logic                rst_ni,
  axi_burst_beat_gen_if.slave bus
);
  localparam logic [2:0] MaxSize    = 3'($clog2(DataWidth / 8));
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] BurstRsvd  = 2'b11;

  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_d;

  logic [IdWidth-1:0]   id_q;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           idx_q, len_q;
  logic [2:0]           size_q;
  logic [1:0]           burst_q;
  logic                 err_q;

  logic beat_valid, beat_last, beat_hs, req_hs;

  assign beat_valid      = (state_q == BUSY);
  assign beat_last       = beat_valid & (idx_q == len_q);
  assign beat_hs         = beat_valid & bus.beat_ready_i;
  assign bus.req_ready_o = (state_q == IDLE) | (beat_hs & beat_last);
  assign req_hs          = bus.req_valid_i & bus.req_ready_o;

  // Legality check on the incoming request; 17 bits covers 256 beats of 128 bytes
  // plus a 12-bit page offset without overflow.
  logic [8:0]  len_p1;
  logic [16:0] blk_mask, burst_bytes, page_end;
  logic        wrap_len_ok, addr_aligned, err_d;

  assign len_p1       = {1'b0, bus.req_len_i} + 9'd1;
  assign blk_mask     = (17'd1 << bus.req_size_i) - 17'd1;
  assign burst_bytes  = {8'd0, len_p1} << bus.req_size_i;
  assign page_end     = ({5'd0, bus.req_addr_i[11:0]} & ~blk_mask) + burst_bytes;
  assign addr_aligned = (bus.req_addr_i[11:0] & blk_mask[11:0]) == 12'd0;
  assign wrap_len_ok  = (bus.req_len_i == 8'd1) | (bus.req_len_i == 8'd3) |
                        (bus.req_len_i == 8'd7) | (bus.req_len_i == 8'd15);

  always_comb begin
    err_d = 1'b0;
    if (bus.req_size_i > MaxSize) err_d = 1'b1;
    case (bus.req_burst_i)
      BurstFixed: if (bus.req_len_i > 8'd15) err_d = 1'b1;
      BurstIncr:  if (page_end > 17'd4096) err_d = 1'b1;
      BurstWrap:  if (!wrap_len_ok || !addr_aligned) err_d = 1'b1;
      BurstRsvd:  err_d = 1'b1;
      default:    err_d = 1'b1;
    endcase
  end

  // Next-beat address; erroneous bursts keep the request address on every beat.
  logic [AddrWidth-1:0] blk_b, wrap_m, addr_nxt;

  assign blk_b  = AddrWidth'(1) << size_q;
  assign wrap_m = ((AddrWidth'(len_q) + AddrWidth'(1)) << size_q) - AddrWidth'(1);

  always_comb begin
    addr_nxt = addr_q;
    if (!err_q) begin
      case (burst_q)
        BurstIncr: addr_nxt = (addr_q & ~(blk_b - AddrWidth'(1))) + blk_b;
        BurstWrap: addr_nxt = (addr_q & ~wrap_m) | ((addr_q + blk_b) & wrap_m);
        default:   addr_nxt = addr_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hs) state_d = BUSY;
      BUSY:    if (beat_hs && beat_last) state_d = req_hs ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q    <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else if (req_hs) begin
      id_q    <= bus.req_id_i;
      addr_q  <= bus.req_addr_i;
      idx_q   <= '0;
      len_q   <= bus.req_len_i;
      size_q  <= bus.req_size_i;
      burst_q <= bus.req_burst_i;
      err_q   <= err_d;
    end else if (beat_hs && !beat_last) begin
      idx_q  <= idx_q + 8'd1;
      addr_q <= addr_nxt;
    end
  end

  assign bus.beat_valid_o = beat_valid;
  assign bus.beat_id_o    = id_q;
  assign bus.beat_addr_o  = addr_q;
  assign bus.beat_idx_o   = idx_q;
  assign bus.beat_last_o  = beat_last;
  assign bus.beat_err_o   = err_q;
endmodule

// File: tb/tb_axi_burst_beat_gen.sv
// Directed bench for axi_burst_beat_gen: expected beats are queued when a request is
// issued and compared as the DUT hands beats over.
module tb_axi_burst_beat_gen;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_burst_beat_gen_if #(.AddrWidth(56), .IdWidth(4)) bus ();

  axi_burst_beat_gen #(.AddrWidth(56), .IdWidth(4), .DataWidth(64)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [55:0] addr;
    logic [7:0]  idx;
    logic        last;
    logic        err;
    logic [3:0]  id;
  } beat_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [55:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } req_t;

  beat_t q[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  string tname    = "reset";

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", tname, tag, got, exp);
    end
  endtask

  task automatic eb(input logic [55:0] a, input int i, input logic l, input logic e,
                    input logic [3:0] id);
    beat_t b;
    b.addr = a; b.idx = 8'(i); b.last = l; b.err = e; b.id = id;
    q.push_back(b);
  endtask

  // Illegal bursts still produce len+1 beats, all at the request address.
  task automatic eb_err(input logic [55:0] a, input int n, input logic [3:0] id);
    for (int i = 0; i < n; i++) eb(a, i, (i == n - 1), 1'b1, id);
  endtask

  task automatic drive(input req_t r);
    bus.req_valid_i = 1'b1;
    bus.req_id_i    = r.id;
    bus.req_addr_i  = r.addr;
    bus.req_len_i   = r.len;
    bus.req_size_i  = r.size;
    bus.req_burst_i = r.burst;
  endtask

  task automatic send_req(input req_t r);
    int w;
    w = 0;
    @(negedge clk);
    drive(r);
    bus.beat_ready_i = 1'b1;
    #1;
    chk("idle_before_req", bus.beat_valid_o, 1'b0);
    while (!bus.req_ready_o && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("req_timeout", (w >= 20), 1'b0);
    @(posedge clk);
  endtask

  task automatic drain(input bit toggle, input bit hold, input req_t nxt);
    int    cyc;
    bit    pend, bub, stall;
    beat_t e, pv;
    cyc = 0; pend = hold; bub = 0; stall = 0; pv = '0;
    while (q.size() > 0 && cyc < 200) begin
      @(negedge clk);
      if (pend) drive(nxt);
      else      bus.req_valid_i = 1'b0;
      bus.beat_ready_i = toggle ? cyc[0] : 1'b1;
      #1;
      if (cyc == 0) chk("first_valid", bus.beat_valid_o, 1'b1);
      if (bub) begin
        chk("no_bubble", bus.beat_valid_o, 1'b1);
        bub = 0;
      end
      if (stall) begin
        chk("hold_addr", bus.beat_addr_o, pv.addr);
        chk("hold_idx",  bus.beat_idx_o,  pv.idx);
        chk("hold_last", bus.beat_last_o, pv.last);
        chk("hold_err",  bus.beat_err_o,  pv.err);
        chk("hold_id",   bus.beat_id_o,   pv.id);
      end
      if (pend) begin
        chk("b2b_req_ready", bus.req_ready_o, q[0].last);
        if (bus.req_ready_o) begin
          pend = 0;
          bub  = 1;
        end
      end
      stall   = bus.beat_valid_o & !bus.beat_ready_i;
      pv.addr = bus.beat_addr_o;
      pv.idx  = bus.beat_idx_o;
      pv.last = bus.beat_last_o;
      pv.err  = bus.beat_err_o;
      pv.id   = bus.beat_id_o;
      if (bus.beat_valid_o && bus.beat_ready_i) begin
        e = q.pop_front();
        chk("addr", bus.beat_addr_o, e.addr);
        chk("idx",  bus.beat_idx_o,  e.idx);
        chk("last", bus.beat_last_o, e.last);
        chk("err",  bus.beat_err_o,  e.err);
        chk("id",   bus.beat_id_o,   e.id);
      end
      cyc++;
    end
    chk("drain_timeout", (cyc >= 200), 1'b0);
  endtask

  req_t none;
  req_t ra, rb;

  initial begin
    none = '0;
    rst_n = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_id_i     = '0;
    bus.req_addr_i   = '0;
    bus.req_len_i    = '0;
    bus.req_size_i   = '0;
    bus.req_burst_i  = '0;
    bus.beat_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", bus.beat_valid_o, 1'b0);
    chk("rst_ready", bus.req_ready_o,  1'b1);
    chk("rst_addr",  bus.beat_addr_o,  56'h0);
    chk("rst_idx",   bus.beat_idx_o,   8'h0);
    chk("rst_last",  bus.beat_last_o,  1'b0);
    chk("rst_err",   bus.beat_err_o,   1'b0);
    chk("rst_id",    bus.beat_id_o,    4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    tname = "incr";
    eb(56'h1000, 0, 0, 0, 4'h1); eb(56'h1008, 1, 0, 0, 4'h1);
    eb(56'h1010, 2, 0, 0, 4'h1); eb(56'h1018, 3, 1, 0, 4'h1);
    send_req('{4'h1, 56'h1000, 8'd3, 3'd3, 2'b01});
    drain(0, 0, none);

    tname = "wrap";
    eb(56'h1038, 0, 0, 0, 4'h2); eb(56'h1020, 1, 0, 0, 4'h2);
    eb(56'h1028, 2, 0, 0, 4'h2); eb(56'h1030, 3, 1, 0, 4'h2);
    send_req('{4'h2, 56'h1038, 8'd3, 3'd3, 2'b10});
    drain(0, 0, none);

    tname = "incr_4k_cross";
    eb_err(56'h0FF8, 2, 4'h3);
    send_req('{4'h3, 56'h0FF8, 8'd1, 3'd3, 2'b01});
    drain(0, 0, none);

    tname = "incr_4k_exact";
    eb(56'h0FF0, 0, 0, 0, 4'h3); eb(56'h0FF8, 1, 1, 0, 4'h3);
    send_req('{4'h3, 56'h0FF0, 8'd1, 3'd3, 2'b01});
    drain(0, 0, none);

    tname = "fixed_stall";
    eb(56'h2004, 0, 0, 0, 4'h4); eb(56'h2004, 1, 0, 0, 4'h4); eb(56'h2004, 2, 1, 0, 4'h4);
    send_req('{4'h4, 56'h2004, 8'd2, 3'd2, 2'b00});
    drain(1, 0, none);

    tname = "rsvd_burst";
    eb_err(56'h2100, 2, 4'h2);
    send_req('{4'h2, 56'h2100, 8'd1, 3'd2, 2'b11});
    drain(0, 0, none);

    tname = "size_too_big";
    eb_err(56'h6008, 1, 4'h9);
    send_req('{4'h9, 56'h6008, 8'd0, 3'd4, 2'b01});
    drain(0, 0, none);

    tname = "wrap_bad_len";
    eb_err(56'h7000, 3, 4'hA);
    send_req('{4'hA, 56'h7000, 8'd2, 3'd2, 2'b10});
    drain(0, 0, none);

    tname = "wrap_unaligned";
    eb_err(56'h1004, 4, 4'hB);
    send_req('{4'hB, 56'h1004, 8'd3, 3'd3, 2'b10});
    drain(0, 0, none);

    tname = "unaligned_b2b";
    ra = '{4'h5, 56'h1003, 8'd2, 3'd2, 2'b01};
    rb = '{4'h6, 56'h3000, 8'd1, 3'd3, 2'b01};
    eb(56'h1003, 0, 0, 0, 4'h5); eb(56'h1004, 1, 0, 0, 4'h5); eb(56'h1008, 2, 1, 0, 4'h5);
    eb(56'h3000, 0, 0, 0, 4'h6); eb(56'h3008, 1, 1, 0, 4'h6);
    send_req(ra);
    drain(0, 1, rb);

    tname = "reset_mid_burst";
    eb(56'h4000, 0, 0, 0, 4'h7); eb(56'h4004, 1, 0, 0, 4'h7);
    send_req('{4'h7, 56'h4000, 8'd7, 3'd2, 2'b01});
    drain(0, 0, none);
    @(negedge clk);
    bus.beat_ready_i = 1'b0;
    #1;
    chk("pre_rst_valid", bus.beat_valid_o, 1'b1);
    chk("pre_rst_idx",   bus.beat_idx_o,   8'd2);
    chk("pre_rst_addr",  bus.beat_addr_o,  56'h4008);
    rst_n = 1'b0;
    #1;
    chk("async_valid", bus.beat_valid_o, 1'b0);
    chk("async_ready", bus.req_ready_o,  1'b1);
    chk("async_idx",   bus.beat_idx_o,   8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    eb(56'h5018, 0, 0, 0, 4'h8); eb(56'h5010, 1, 1, 0, 4'h8);
    send_req('{4'h8, 56'h5018, 8'd1, 3'd3, 2'b10});
    drain(0, 0, none);

    tname = "end";
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    #1;
    chk("final_idle", bus.beat_valid_o, 1'b0);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
